app_infifo: RTL and testbench

Input buffer and launch controller between the AHB slave write path and the XOR application codec. Buffers 32-bit words written by the AHB slave in a first-word-fall-through (FWFT) FIFO. Presents the head word combinationally on the codec `datain`. Issues the single-cycle `app_start` to the codec only when a full block is resident, so the codec can never pop an empty FIFO.

---
 rtl/app_pkg.sv | 15 +
 rtl/app_sync_fifo.sv | 65 ++++++
 rtl/app_infifo.sv | 79 +++++++
 tb/tb_app_infifo.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/app_pkg.sv
// Shared definitions for the application codec input path: launch FSM states
// and default buffer geometry.
package app_pkg;

  localparam int APP_DEPTH = 32;
  localparam int APP_WIDTH = 32;
  localparam int BS_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } app_state_e;

endpackage

// File: rtl/app_sync_fifo.sv
// First-word-fall-through FIFO with separate level counter and sticky
// overflow/underflow flags.
module app_sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             hreset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the concurrent write lands in.
  assign pop_ok  = pop && !empty;
  assign push_ok = wr_en && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      // A fresh error takes priority over a same-cycle clear.
      if (wr_en && !push_ok) ovf <= 1'b1;
      else if (clr_err)      ovf <= 1'b0;
      if (pop && empty)      udf <= 1'b1;
      else if (clr_err)      udf <= 1'b0;
    end
  end

endmodule

// File: rtl/app_infifo.sv
// Input buffer for the XOR codec: buffers AHB writes and launches the codec
// only once a whole block is resident.
module app_infifo
  import app_pkg::*;
#(
  parameter int DEPTH = APP_DEPTH,
  parameter int WIDTH = APP_WIDTH,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             hreset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [BS_W-1:0]  block_size,
  input  logic             enable,
  input  logic             pop,
  input  logic             done,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             app_start,
  output logic             busy,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             udf
);

  app_state_e state_q;
  app_state_e state_d;
  logic       trigger;

  app_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .hreset  (hreset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .clr_err (clr_err),
    .dout    (dout),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
  );

  // block_size only matters here, while IDLE; the codec keeps its own copy.
  assign trigger = enable && (block_size != '0) && !busy &&
                   (level >= (AW+1)'(block_size));

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    app_start = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE:    if (trigger) state_d = LAUNCH;
      LAUNCH: begin
        app_start = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_app_infifo.sv
// Bench for app_infifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_app_infifo;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             hreset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       block_size;
  logic             enable;
  logic             pop;
  logic             done;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             app_start;
  logic             busy;
  logic [AW:0]      level;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             udf;

  app_infifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk        (clk),
    .hreset     (hreset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .block_size (block_size),
    .enable     (enable),
    .pop        (pop),
    .done       (done),
    .clr_err    (clr_err),
    .dout       (dout),
    .app_start  (app_start),
    .busy       (busy),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .udf        (udf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic [4:0]  bs;
    logic        en;
    logic        pp;
    logic        dn;
    logic        clr;
    int          lvl;
    logic        st;
    logic        bz;
    logic        ov;
    logic        ud;
    logic        dchk;
    logic [31:0] dv;
  } vec_t;

  vec_t tbl[15];

  logic [31:0] q[$];
  bit          m_ovf, m_udf, m_start, m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en   = 1'b0;
    pop     = 1'b0;
    done    = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    enable     = 1'b0;
    block_size = 5'd0;
    wr_data    = '0;
    hreset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hreset = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    hreset = 1'b1;
    do_reset();

    chk("rst level", level, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst start", app_start, 0);
    chk("rst busy", busy, 0);
    chk("rst ovf", ovf, 0);
    chk("rst udf", udf, 0);

    //             wr d      bs en pp dn clr lvl st bz ov ud dchk dv
    tbl[0]  = '{1, 32'h1,  4, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 32'h1};
    tbl[1]  = '{1, 32'h2,  4, 1, 0, 0, 0,  2, 0, 0, 0, 0, 1, 32'h1};
    tbl[2]  = '{1, 32'h3,  4, 1, 0, 0, 0,  3, 0, 0, 0, 0, 1, 32'h1};
    tbl[3]  = '{1, 32'h4,  4, 1, 0, 0, 0,  4, 0, 0, 0, 0, 1, 32'h1};
    tbl[4]  = '{0, 32'h0,  4, 1, 0, 0, 0,  4, 1, 0, 0, 0, 1, 32'h1};
    tbl[5]  = '{0, 32'h0,  4, 1, 0, 0, 0,  4, 0, 1, 0, 0, 1, 32'h1};
    tbl[6]  = '{0, 32'h0,  4, 1, 1, 0, 0,  3, 0, 1, 0, 0, 1, 32'h2};
    tbl[7]  = '{0, 32'h0,  4, 1, 1, 0, 0,  2, 0, 1, 0, 0, 1, 32'h3};
    tbl[8]  = '{0, 32'h0,  4, 1, 1, 0, 0,  1, 0, 1, 0, 0, 1, 32'h4};
    tbl[9]  = '{0, 32'h0,  4, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 32'h0};
    tbl[10] = '{0, 32'h0,  4, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 32'h0};
    tbl[11] = '{0, 32'h0,  4, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 32'h0};
    tbl[12] = '{1, 32'hAA, 4, 0, 1, 0, 0,  1, 0, 0, 0, 1, 1, 32'hAA};
    tbl[13] = '{0, 32'h0,  4, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 32'h0};
    tbl[14] = '{0, 32'h0,  4, 0, 1, 0, 1,  0, 0, 0, 0, 1, 0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      wr_en      = tbl[i].wr;
      wr_data    = tbl[i].d;
      block_size = tbl[i].bs;
      enable     = tbl[i].en;
      pop        = tbl[i].pp;
      done       = tbl[i].dn;
      clr_err    = tbl[i].clr;
      tick();
      chk($sformatf("v%0d level", i), level, tbl[i].lvl);
      chk($sformatf("v%0d empty", i), empty, (tbl[i].lvl == 0));
      chk($sformatf("v%0d start", i), app_start, tbl[i].st);
      chk($sformatf("v%0d busy", i), busy, tbl[i].bz);
      chk($sformatf("v%0d ovf", i), ovf, tbl[i].ov);
      chk($sformatf("v%0d udf", i), udf, tbl[i].ud);
      if (tbl[i].dchk) chk($sformatf("v%0d dout", i), dout, tbl[i].dv);
    end
    idle_in();

    // Overflow: 33rd word dropped, flag sticky until cleared.
    do_reset();
    for (int i = 0; i < 32; i++) wr_word(32'h100 + i);
    chk("ovf32 level", level, 32);
    chk("ovf32 full", full, 1);
    chk("ovf32 ovf", ovf, 0);
    wr_word(32'h999);
    chk("ovf33 ovf", ovf, 1);
    chk("ovf33 level", level, 32);
    chk("ovf33 full", full, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf clr", ovf, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("ovf rd%0d", i), dout, 32'h100 + i);
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk("ovf drained empty", empty, 1);
    chk("ovf drained level", level, 0);

    // Launch threshold: 7 of 8 words never launches.
    do_reset();
    block_size = 5'd8;
    enable     = 1'b1;
    for (int i = 0; i < 7; i++) wr_word(32'h20 + i);
    repeat (2) begin
      tick();
      chk("bs8 no start", app_start, 0);
    end
    wr_word(32'h27);
    chk("bs8 8th start", app_start, 0);
    chk("bs8 level", level, 8);
    tick();
    chk("bs8 start", app_start, 1);
    tick();
    chk("bs8 busy", busy, 1);
    chk("bs8 start gone", app_start, 0);

    // block_size change in RUN only affects the next launch.
    do_reset();
    block_size = 5'd4;
    enable     = 1'b1;
    for (int i = 0; i < 4; i++) wr_word(32'h40 + i);
    tick();
    chk("run start", app_start, 1);
    block_size = 5'd2;
    wr_word(32'h50);
    chk("run busy", busy, 1);
    wr_word(32'h51);
    chk("run no start", app_start, 0);
    chk("run level", level, 6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("run rd%0d", i), dout, 32'h40 + i);
      pop  = 1'b1;
      done = (i == 3);
      tick();
      chk("run no restart", app_start, 0);
    end
    pop  = 1'b0;
    done = 1'b0;
    chk("run done busy", busy, 0);
    chk("run done level", level, 2);
    tick();
    chk("run relaunch bs2", app_start, 1);

    // Asynchronous reset in the middle of a block.
    do_reset();
    block_size = 5'd3;
    enable     = 1'b1;
    for (int i = 0; i < 3; i++) wr_word(32'h60 + i);
    tick();
    tick();
    chk("arst pre busy", busy, 1);
    chk("arst pre level", level, 3);
    #2;
    hreset = 1'b1;
    #1;
    chk("arst level", level, 0);
    chk("arst busy", busy, 0);
    chk("arst empty", empty, 1);
    chk("arst start", app_start, 0);
    @(negedge clk);
    hreset = 1'b0;
    block_size = 5'd1;
    wr_word(32'h55);
    chk("arst resume level", level, 1);
    chk("arst resume dout", dout, 32'h55);
    tick();
    chk("arst resume start", app_start, 1);

    // Randomized run against the reference model.
    do_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_start = 0; m_busy = 0;
    block_size = 5'd4;
    for (int c = 0; c < 3000; c++) begin
      int  sz;
      bit  pop_ok, push_ok, n_start, n_busy;
      bit  heavy_wr;
      heavy_wr = ((c / 150) % 2) == 0;
      wr_en   = heavy_wr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      wr_data = $urandom;
      pop     = heavy_wr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      done    = ($urandom_range(0, 5) == 0);
      clr_err = ($urandom_range(0, 15) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) block_size = 5'($urandom_range(0, 31));

      sz      = q.size();
      pop_ok  = pop && (sz > 0);
      push_ok = wr_en && ((sz < DEPTH) || pop_ok);
      n_start = !m_start && !m_busy && enable && (block_size != 0) && (sz >= int'(block_size));
      n_busy  = m_start || (m_busy && !done);
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(wr_data);
      if (wr_en && !push_ok)  m_ovf = 1;
      else if (clr_err)       m_ovf = 0;
      if (pop && (sz == 0))   m_udf = 1;
      else if (clr_err)       m_udf = 0;
      m_start = n_start;
      m_busy  = n_busy;

      tick();
      chk("rnd level", level, q.size());
      chk("rnd full", full, (q.size() == DEPTH));
      chk("rnd empty", empty, (q.size() == 0));
      chk("rnd ovf", ovf, m_ovf);
      chk("rnd udf", udf, m_udf);
      chk("rnd start", app_start, m_start);
      chk("rnd busy", busy, m_busy);
      if (q.size() > 0) chk("rnd dout", dout, q[0]);
    end
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
